// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer for the single-cycle core. It holds the PC and
// picks the next PC from one of these sources: sequential, jump, branch,
// call, or return. Calls and returns go through a small circular
// return-address stack. The PC freezes while either cache is busy. The block
// boots into RUN one edge after reset, and it halts permanently on HALT.
//
// Ports
//   i_clk          clock, all state changes on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_ibusywait    instruction cache not ready
//   i_dbusywait    data cache not ready
//   i_jump         unconditional PC-relative jump
//   i_branch       conditional branch
//   i_branch_ne    with i_branch: 1 = branch-if-not-equal, 0 = branch-if-equal
//   i_zero         ALU zero flag
//   i_call         jump to target and push the return address
//   i_ret          return to the popped stack address
//   i_halt         enter HALTED after this cycle's PC update
//   i_offset       signed offset, counted in instructions
//   o_pc           current instruction address
//   o_pc_plus      o_pc + INSTR_BYTES
//   o_iread        fetch request
//   o_instr_valid  fetched instruction usable this cycle
//   o_taken        previous PC update was a redirect
//   o_ras_count    number of valid stack entries
//   o_ras_err      sticky flag: a return was seen on an empty stack
//
// state    | meaning
// ---------+------------------------------------------------
// ST_BOOT  | out of reset, PC held, no fetch; RUN on next edge
// ST_RUN   | fetching and sequencing
// ST_HALT  | frozen until reset
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int                   PC_WIDTH     = 32,
    parameter int                   OFFSET_WIDTH = 8,
    parameter int                   INSTR_BYTES  = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int                   RAS_DEPTH    = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_ibusywait,
    input  logic                              i_dbusywait,
    input  logic                              i_jump,
    input  logic                              i_branch,
    input  logic                              i_branch_ne,
    input  logic                              i_zero,
    input  logic                              i_call,
    input  logic                              i_ret,
    input  logic                              i_halt,
    input  logic [OFFSET_WIDTH-1:0]           i_offset,
    output logic [PC_WIDTH-1:0]               o_pc,
    output logic [PC_WIDTH-1:0]               o_pc_plus,
    output logic                              o_iread,
    output logic                              o_instr_valid,
    output logic                              o_taken,
    output logic [$clog2(RAS_DEPTH+1)-1:0]    o_ras_count,
    output logic                              o_ras_err
);

    localparam int SHIFT = $clog2(INSTR_BYTES);
    localparam int CW    = $clog2(RAS_DEPTH + 1);
    localparam int PW    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [PW-1:0] PTR_LAST = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]          r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_taken;
    logic [CW-1:0]       r_ras_count;
    logic                r_ras_err;
    logic [PW-1:0]       r_ras_ptr;
    logic [PC_WIDTH-1:0] r_ras [RAS_DEPTH];

    logic [1:0]          w_state_nxt;
    logic [PC_WIDTH-1:0] w_pc_nxt;
    logic                w_taken_nxt;
    logic [CW-1:0]       w_ras_count_nxt;
    logic                w_ras_err_nxt;
    logic [PW-1:0]       w_ras_ptr_nxt;
    logic                w_ras_we;
    logic [PW-1:0]       w_ras_waddr;

    logic                w_stall;
    logic [PC_WIDTH-1:0] w_pc_plus;
    logic [PC_WIDTH-1:0] w_off_sx;
    logic [PC_WIDTH-1:0] w_target;
    logic                w_br_taken;
    logic [PW-1:0]       w_ptr_inc;
    logic [PW-1:0]       w_ptr_dec;
    logic [PC_WIDTH-1:0] w_ras_top;
    logic                w_ras_empty;

    assign w_stall     = i_ibusywait | i_dbusywait;
    assign w_pc_plus   = r_pc + PC_WIDTH'(INSTR_BYTES);
    assign w_off_sx    = {{(PC_WIDTH-OFFSET_WIDTH){i_offset[OFFSET_WIDTH-1]}}, i_offset};
    assign w_target    = w_pc_plus + (w_off_sx << SHIFT);
    assign w_br_taken  = i_branch & (i_zero ^ i_branch_ne);

    // r_ras_ptr is the next slot to write. The top of the stack is the slot
    // just below it.
    assign w_ptr_inc   = (r_ras_ptr == PTR_LAST) ? '0 : r_ras_ptr + 1'b1;
    assign w_ptr_dec   = (r_ras_ptr == '0) ? PTR_LAST : r_ras_ptr - 1'b1;
    assign w_ras_top   = r_ras[w_ptr_dec];
    assign w_ras_empty = (r_ras_count == '0);

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_taken_nxt     = 1'b0;
        w_ras_count_nxt = r_ras_count;
        w_ras_err_nxt   = r_ras_err;
        w_ras_ptr_nxt   = r_ras_ptr;
        w_ras_we        = 1'b0;
        w_ras_waddr     = r_ras_ptr;

        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (!w_stall) begin
                    if (i_halt) w_state_nxt = ST_HALT;
                    if (i_ret) begin
                        if (w_ras_empty) begin
                            w_pc_nxt      = w_pc_plus;
                            w_ras_err_nxt = 1'b1;
                        end else begin
                            w_pc_nxt    = w_ras_top;
                            w_taken_nxt = 1'b1;
                        end
                        if (i_call) begin
                            // Call and return in the same cycle: the top entry
                            // is swapped in place. On an empty stack this acts
                            // as a plain push.
                            w_ras_we = 1'b1;
                            if (w_ras_empty) begin
                                w_ras_ptr_nxt   = w_ptr_inc;
                                w_ras_count_nxt = CW'(1);
                            end else begin
                                w_ras_waddr = w_ptr_dec;
                            end
                        end else if (!w_ras_empty) begin
                            w_ras_ptr_nxt   = w_ptr_dec;
                            w_ras_count_nxt = r_ras_count - 1'b1;
                        end
                    end else if (i_call) begin
                        w_pc_nxt      = w_target;
                        w_taken_nxt   = 1'b1;
                        w_ras_we      = 1'b1;
                        w_ras_ptr_nxt = w_ptr_inc;
                        // A full stack overwrites its oldest entry, so the
                        // count stops at the depth.
                        if (r_ras_count != CNT_FULL)
                            w_ras_count_nxt = r_ras_count + 1'b1;
                    end else if (i_jump || w_br_taken) begin
                        w_pc_nxt    = w_target;
                        w_taken_nxt = 1'b1;
                    end else begin
                        w_pc_nxt = w_pc_plus;
                    end
                end
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_VECTOR;
            r_taken     <= 1'b0;
            r_ras_count <= '0;
            r_ras_err   <= 1'b0;
            r_ras_ptr   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_taken     <= w_taken_nxt;
            r_ras_count <= w_ras_count_nxt;
            r_ras_err   <= w_ras_err_nxt;
            r_ras_ptr   <= w_ras_ptr_nxt;
        end
    end

    // Stack storage has no reset. A zero count makes any stale contents
    // unreachable.
    always_ff @(posedge i_clk) begin
        if (w_ras_we) r_ras[w_ras_waddr] <= w_pc_plus;
    end

    assign o_pc          = r_pc;
    assign o_pc_plus     = w_pc_plus;
    assign o_iread       = (r_state == ST_RUN);
    assign o_instr_valid = (r_state == ST_RUN) & ~i_ibusywait;
    assign o_taken       = r_taken;
    assign o_ras_count   = r_ras_count;
    assign o_ras_err     = r_ras_err;

endmodule
